// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch redirect controller: PC-select codes,
// controller state and the kind of redirect held while the backend stalls.
package fetch_pkg;

    localparam logic [1:0] PCSEL_PLUS4 = 2'b00;
    localparam logic [1:0] PCSEL_DEC   = 2'b01;
    localparam logic [1:0] PCSEL_ALU   = 2'b10;
    localparam logic [1:0] PCSEL_EXC   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_TRAP = 2'd2
    } fsm_state_e;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_DEC  = 2'd1,
        PEND_ALU  = 2'd2
    } pend_kind_e;

endpackage

// File: rtl/redirect_pending_buf.sv
// Holds one redirect (kind + target) captured while the backend stalls.
// An execute redirect outranks a decode redirect; clear outranks capture.
module redirect_pending_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_cap_alu,
    input  logic        i_cap_dec,
    input  logic [31:0] i_alu_tgt,
    input  logic [31:0] i_dec_tgt,
    output logic [1:0]  o_kind,
    output logic [31:0] o_tgt
);

    pend_kind_e  r_kind;
    logic [31:0] r_tgt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_kind <= PEND_NONE;
            r_tgt  <= '0;
        end else if (i_cap_alu) begin
            r_kind <= PEND_ALU;
            r_tgt  <= i_alu_tgt;
        end else if (i_cap_dec && (r_kind != PEND_ALU)) begin
            // the older execute redirect already pending must survive
            r_kind <= PEND_DEC;
            r_tgt  <= i_dec_tgt;
        end
    end

    assign o_kind = r_kind;
    assign o_tgt  = r_tgt;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage sequencing: arbitrates exception / execute / decode redirects
// against backend stalls. Define FETCH_REDIRECT_PERF_EN for perf counters.
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter int TRAP_CYCLES = 2
`ifdef FETCH_REDIRECT_PERF_EN
    ,
    parameter int PERF_W      = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_in,
    input  logic              alu_redir_in,
    input  logic [31:0]       alu_tgt_in,
    input  logic              dec_redir_in,
    input  logic [31:0]       dec_tgt_in,
    input  logic              stall_in,
    output logic              pc_s0_out,
    output logic              pc_s1_out,
    output logic [31:0]       pc_dec_out,
    output logic [31:0]       pc_alu_out,
    output logic              pc_en_out,
    output logic              ex_out,
    output logic              flush_if_out,
    output logic              flush_id_out,
    output logic              trap_busy_out,
`ifdef FETCH_REDIRECT_PERF_EN
    output logic [PERF_W-1:0] perf_redir_cnt_out,
    output logic [PERF_W-1:0] perf_stall_cnt_out,
`endif
    output logic [1:0]        dbg_state_out
);

    localparam int CNT_W = (TRAP_CYCLES > 1) ? $clog2(TRAP_CYCLES) : 1;

    fsm_state_e       r_state;
    logic [CNT_W-1:0] r_trap_cnt;

    logic [1:0]  w_sel;
    logic        w_pc_en;
    logic        w_ex;
    logic        w_flush_if;
    logic        w_flush_id;
    logic        w_trap_busy;
    logic [31:0] w_pc_alu;
    logic [31:0] w_pc_dec;
    logic        w_cap_alu;
    logic        w_cap_dec;
    logic        w_clear;
    logic [1:0]  w_pend_kind;
    logic [31:0] w_pend_tgt;

    redirect_pending_buf u_pend (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_cap_alu (w_cap_alu),
        .i_cap_dec (w_cap_dec),
        .i_alu_tgt (alu_tgt_in),
        .i_dec_tgt (dec_tgt_in),
        .o_kind    (w_pend_kind),
        .o_tgt     (w_pend_tgt)
    );

    always_comb begin
        w_sel       = PCSEL_PLUS4;
        w_pc_en     = 1'b0;
        w_ex        = 1'b0;
        w_flush_if  = 1'b0;
        w_flush_id  = 1'b0;
        w_trap_busy = 1'b0;
        w_pc_alu    = alu_tgt_in;
        w_pc_dec    = dec_tgt_in;
        w_cap_alu   = 1'b0;
        w_cap_dec   = 1'b0;
        w_clear     = 1'b0;
        if (rst) begin
            w_flush_if = 1'b1;
            w_flush_id = 1'b1;
            w_pc_alu   = '0;
            w_pc_dec   = '0;
        end else begin
            case (r_state)
                ST_RUN, ST_HOLD: begin
                    if (r_state == ST_HOLD) begin
                        if (w_pend_kind == PEND_ALU) w_pc_alu = w_pend_tgt;
                        if (w_pend_kind == PEND_DEC) w_pc_dec = w_pend_tgt;
                    end
                    if (ex_in) begin
                        w_sel      = PCSEL_EXC;
                        w_ex       = 1'b1;
                        w_pc_en    = 1'b1;
                        w_flush_if = 1'b1;
                        w_flush_id = 1'b1;
                        w_clear    = 1'b1;
                    end else if (stall_in) begin
                        w_cap_alu = alu_redir_in;
                        w_cap_dec = dec_redir_in && !alu_redir_in;
                    end else if (r_state == ST_HOLD) begin
                        // release: pending alu beats a live one (older), live alu beats pending dec
                        w_pc_en = 1'b1;
                        w_clear = 1'b1;
                        if ((w_pend_kind == PEND_ALU) || alu_redir_in) begin
                            w_sel      = PCSEL_ALU;
                            w_flush_if = 1'b1;
                            w_flush_id = 1'b1;
                        end else begin
                            w_sel      = PCSEL_DEC;
                            w_flush_if = 1'b1;
                        end
                    end else begin
                        w_pc_en = 1'b1;
                        if (alu_redir_in) begin
                            w_sel      = PCSEL_ALU;
                            w_flush_if = 1'b1;
                            w_flush_id = 1'b1;
                        end else if (dec_redir_in) begin
                            w_sel      = PCSEL_DEC;
                            w_flush_if = 1'b1;
                        end
                    end
                end
                ST_TRAP: begin
                    w_trap_busy = 1'b1;
                    w_flush_if  = 1'b1;
                    w_flush_id  = 1'b1;
                end
                default: begin
                    w_flush_if = 1'b1;
                    w_flush_id = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_trap_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ex_in) begin
                        r_state    <= ST_TRAP;
                        r_trap_cnt <= CNT_W'(TRAP_CYCLES - 1);
                    end else if (stall_in && (alu_redir_in || dec_redir_in)) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ex_in) begin
                        r_state    <= ST_TRAP;
                        r_trap_cnt <= CNT_W'(TRAP_CYCLES - 1);
                    end else if (!stall_in) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_TRAP: begin
                    if (r_trap_cnt == '0) r_state <= ST_RUN;
                    else                  r_trap_cnt <= r_trap_cnt - 1'b1;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef FETCH_REDIRECT_PERF_EN
    logic [PERF_W-1:0] r_redir_cnt;
    logic [PERF_W-1:0] r_stall_cnt;

    // a non-plus4 select only ever appears in the cycle a redirect/exception applies
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redir_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_sel != PCSEL_PLUS4) r_redir_cnt <= r_redir_cnt + 1'b1;
            if (!w_pc_en)             r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign perf_redir_cnt_out = r_redir_cnt;
    assign perf_stall_cnt_out = r_stall_cnt;
`endif

    assign pc_s0_out     = w_sel[0];
    assign pc_s1_out     = w_sel[1];
    assign pc_alu_out    = w_pc_alu;
    assign pc_dec_out    = w_pc_dec;
    assign pc_en_out     = w_pc_en;
    assign ex_out        = w_ex;
    assign flush_if_out  = w_flush_if;
    assign flush_id_out  = w_flush_id;
    assign trap_busy_out = w_trap_busy;
    assign dbg_state_out = r_state;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios then random traffic,
// checked against a rule-level model and an emulated fetch PC.
module tb_fetch_redirect_ctrl;

    localparam int          TRAP_CYCLES = 2;
    localparam logic [31:0] EXC_VEC     = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, ex_in, alu_redir_in, dec_redir_in, stall_in;
    logic [31:0] alu_tgt_in, dec_tgt_in;
    logic        pc_s0_out, pc_s1_out, pc_en_out, ex_out;
    logic        flush_if_out, flush_id_out, trap_busy_out;
    logic [31:0] pc_dec_out, pc_alu_out;
    logic [1:0]  dbg_state_out;
`ifdef FETCH_REDIRECT_PERF_EN
    logic [31:0] perf_redir_cnt_out, perf_stall_cnt_out;
`endif

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(.TRAP_CYCLES(TRAP_CYCLES)) dut (
        .clk                (clk),
        .rst                (rst),
        .ex_in              (ex_in),
        .alu_redir_in       (alu_redir_in),
        .alu_tgt_in         (alu_tgt_in),
        .dec_redir_in       (dec_redir_in),
        .dec_tgt_in         (dec_tgt_in),
        .stall_in           (stall_in),
        .pc_s0_out          (pc_s0_out),
        .pc_s1_out          (pc_s1_out),
        .pc_dec_out         (pc_dec_out),
        .pc_alu_out         (pc_alu_out),
        .pc_en_out          (pc_en_out),
        .ex_out             (ex_out),
        .flush_if_out       (flush_if_out),
        .flush_id_out       (flush_id_out),
        .trap_busy_out      (trap_busy_out),
`ifdef FETCH_REDIRECT_PERF_EN
        .perf_redir_cnt_out (perf_redir_cnt_out),
        .perf_stall_cnt_out (perf_stall_cnt_out),
`endif
        .dbg_state_out      (dbg_state_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: trap cycles remaining, optional pending redirect, fetch PCs, perf counts
    int          m_trap_left = 0;
    bit          m_pend      = 1'b0;
    bit          m_pend_alu  = 1'b0;
    logic [31:0] m_pend_tgt  = '0;
    logic [31:0] m_pc        = '0;
    logic [31:0] d_pc        = '0;
    int unsigned m_redir     = 0;
    int unsigned m_stall     = 0;

    // {sel[1:0], pc_en, ex, flush_if, flush_id, trap_busy, target[31:0]}
    logic [38:0] exp_q[$];

    task automatic step(input bit r, input bit e, input bit a, input logic [31:0] at,
                        input bit d, input logic [31:0] dt, input bit s);
        logic [1:0]  e_sel;
        logic        e_en, e_ex, e_fif, e_fid, e_busy;
        logic [31:0] e_tgt;
        logic [38:0] exp_v;
        rst = r; ex_in = e; alu_redir_in = a; alu_tgt_in = at;
        dec_redir_in = d; dec_tgt_in = dt; stall_in = s;
        @(negedge clk);
        e_sel = 2'd0; e_en = 0; e_ex = 0; e_fif = 0; e_fid = 0; e_busy = 0; e_tgt = '0;
        if (r) begin
            e_fif = 1; e_fid = 1;
            m_trap_left = 0; m_pend = 0;
        end else if (m_trap_left > 0) begin
            e_busy = 1; e_fif = 1; e_fid = 1;
            m_trap_left--;
        end else if (e) begin
            e_sel = 2'd3; e_ex = 1; e_en = 1; e_fif = 1; e_fid = 1;
            m_pend = 0; m_trap_left = TRAP_CYCLES;
        end else if (s) begin
            if (a) begin
                m_pend = 1; m_pend_alu = 1; m_pend_tgt = at;
            end else if (d && !(m_pend && m_pend_alu)) begin
                m_pend = 1; m_pend_alu = 0; m_pend_tgt = dt;
            end
        end else if (m_pend) begin
            e_en = 1;
            if (m_pend_alu)  begin e_sel = 2'd2; e_tgt = m_pend_tgt; e_fif = 1; e_fid = 1; end
            else if (a)      begin e_sel = 2'd2; e_tgt = at;         e_fif = 1; e_fid = 1; end
            else             begin e_sel = 2'd1; e_tgt = m_pend_tgt; e_fif = 1; end
            m_pend = 0;
        end else begin
            e_en = 1;
            if (a)      begin e_sel = 2'd2; e_tgt = at; e_fif = 1; e_fid = 1; end
            else if (d) begin e_sel = 2'd1; e_tgt = dt; e_fif = 1; end
        end
        exp_q.push_back({e_sel, e_en, e_ex, e_fif, e_fid, e_busy, e_tgt});

        exp_v = exp_q.pop_front();
        check("sel",       {62'd0, pc_s1_out, pc_s0_out}, {62'd0, exp_v[38:37]});
        check("pc_en",     {63'd0, pc_en_out},     {63'd0, exp_v[36]});
        check("ex_out",    {63'd0, ex_out},        {63'd0, exp_v[35]});
        check("flush_if",  {63'd0, flush_if_out},  {63'd0, exp_v[34]});
        check("flush_id",  {63'd0, flush_id_out},  {63'd0, exp_v[33]});
        check("trap_busy", {63'd0, trap_busy_out}, {63'd0, exp_v[32]});
        if (r) begin
            check("pc_alu_rst", {32'd0, pc_alu_out}, 64'd0);
            check("pc_dec_rst", {32'd0, pc_dec_out}, 64'd0);
        end else if (exp_v[38:37] == 2'd2) begin
            check("pc_alu", {32'd0, pc_alu_out}, {32'd0, exp_v[31:0]});
        end else if (exp_v[38:37] == 2'd1) begin
            check("pc_dec", {32'd0, pc_dec_out}, {32'd0, exp_v[31:0]});
        end

`ifdef FETCH_REDIRECT_PERF_EN
        check("perf_redir", {32'd0, perf_redir_cnt_out}, {32'd0, m_redir});
        check("perf_stall", {32'd0, perf_stall_cnt_out}, {32'd0, m_stall});
        if (!r) begin
            if (exp_v[38:37] != 2'd0) m_redir++;
            if (!exp_v[36])           m_stall++;
        end else begin
            m_redir = 0; m_stall = 0;
        end
`endif

        // emulated fetch PC register, once from the DUT pins and once from the model
        if (r) d_pc = '0;
        else if (pc_en_out)
            case ({pc_s1_out, pc_s0_out})
                2'b00:   d_pc = d_pc + 32'd4;
                2'b01:   d_pc = pc_dec_out;
                2'b10:   d_pc = pc_alu_out;
                default: d_pc = EXC_VEC;
            endcase
        if (r) m_pc = '0;
        else if (exp_v[36])
            case (exp_v[38:37])
                2'd0:    m_pc = m_pc + 32'd4;
                2'd3:    m_pc = EXC_VEC;
                default: m_pc = exp_v[31:0];
            endcase
        check("fetch_pc", {32'd0, d_pc}, {32'd0, m_pc});

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0, 0);
    endtask

    initial begin
        bit          r_s;
        logic [31:0] at_s, dt_s;
        rst = 1; ex_in = 0; alu_redir_in = 0; dec_redir_in = 0; stall_in = 0;
        alu_tgt_in = '0; dec_tgt_in = '0;

        // reset then free-running fetch
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, '0, 0);
        check("state_after_rst", {62'd0, dbg_state_out}, 64'd0);
        idle(4);

        // same-cycle alu and dec redirect: alu wins
        step(0, 0, 1, 32'h200, 1, 32'h100, 0);
        idle(2);

        // stall with dec then alu, release applies the alu target
        step(0, 0, 0, '0, 1, 32'h40, 1);
        step(0, 0, 1, 32'h80, 0, '0, 1);
        step(0, 0, 0, '0, 1, 32'h44, 1);
        step(0, 0, 0, '0, 0, '0, 1);
        step(0, 0, 0, '0, 0, '0, 0);
        idle(2);

        // live alu beats pending dec in the release cycle
        step(0, 0, 0, '0, 1, 32'h300, 1);
        step(0, 0, 1, 32'h400, 0, '0, 0);
        idle(1);

        // exception during HOLD, redirects ignored in TRAP
        step(0, 0, 0, '0, 1, 32'h500, 1);
        step(0, 1, 0, '0, 0, '0, 1);
        step(0, 1, 1, 32'h600, 1, 32'h700, 0);
        step(0, 0, 1, 32'h604, 0, '0, 0);
        idle(3);

        // reset while trapping
        step(0, 1, 0, '0, 0, '0, 0);
        step(1, 0, 0, '0, 0, '0, 0);
        idle(3);

        // perf scenario: 3 redirects and 5 stall cycles after a reset
        step(1, 0, 0, '0, 0, '0, 0);
        step(0, 0, 1, 32'h900, 0, '0, 0);
        step(0, 0, 0, '0, 1, 32'ha00, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 0, '0, 1);
        step(0, 0, 0, '0, 1, 32'hb00, 0);
        idle(1);

        // randomized traffic with bursty stalls
        stall_in = 0;
        for (int i = 0; i < 800; i++) begin
            bit s_n;
            r_s  = ($urandom_range(0, 149) == 0);
            at_s = $urandom & 32'hffff_fffc;
            dt_s = $urandom & 32'hffff_fffc;
            s_n  = ($urandom_range(0, 3) == 0) ? ~stall_in : stall_in;
            step(r_s, $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0, at_s,
                 $urandom_range(0, 4) == 0, dt_s, s_n);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
